// File: rtl/uart_rx_framer_pkg.sv
// Shared definitions for the UART receive framer: FSM state encoding,
// the default baud divisor and the 3-sample majority helper.
package uart_rx_framer_pkg;

    localparam int CLOCKS_PER_BAUD_DEFAULT = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable down-counter for bit timing; holds at zero and reports it,
// so it never wraps between reloads.
module uart_baud_timer #(
    parameter int TIMER_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  enable_i,
    input  logic [TIMER_BITS-1:0] load_val_i,
    output logic                  zero_o
);

    logic [TIMER_BITS-1:0] cnt_q;
    logic [TIMER_BITS-1:0] cnt_d;

    // NOTE: always_comb assigns every output a default first, so no latch can be inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_BITS'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 oversampling UART receiver: pin synchroniser, mid-bit majority vote,
// frame FSM and a valid/ready output register with framing/overrun pulses.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEFAULT,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [TIMER_BITS-1:0] HALF_LOAD = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [TIMER_BITS-1:0] FULL_LOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    logic                 sync1_q, sync2_q;
    logic [1:0]           fill_q;
    logic [2:0]           hist_q;
    logic                 armed_q;
    state_e               state_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 deliver_q;
    logic                 frame_err_q;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                  rx_s;
    logic                  vote;
    logic                  timer_zero;
    logic                  timer_load;
    logic [TIMER_BITS-1:0] timer_val;

    assign rx_s = sync2_q;
    assign vote = majority3(hist_q);

    // fill_q marks when the synchroniser holds real pin samples rather than
    // reset values, so a line held low across reset cannot arm the receiver.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
            fill_q  <= {fill_q[0], 1'b1};
            if (fill_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign timer_load = ((state_q == ST_IDLE) && armed_q && !rx_s) ||
                        (((state_q == ST_START) || (state_q == ST_DATA)) && timer_zero);
    assign timer_val  = (state_q == ST_IDLE) ? HALF_LOAD : FULL_LOAD;

    uart_baud_timer #(
        .TIMER_BITS (TIMER_BITS)
    ) u_baud_timer (
        .clk        (clk),
        .rst_i      (i_reset),
        .load_i     (timer_load),
        .enable_i   (1'b1),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (armed_q && !rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    if (timer_zero) begin
                        if (vote) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (timer_zero) begin
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets the next start edge be caught early.
                    if (timer_zero) begin
                        if (vote) begin
                            deliver_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver_q) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: reset, timing, glitch, framing,
// overrun, mid-frame reset, spike filtering and randomized 8N1 traffic.
module tb_uart_rx_framer;

    localparam int C      = 16;
    localparam int H      = C / 2;
    localparam int NBITS  = 8;
    localparam int SPIKE_OFS = 6;
    localparam int LATENCY = 1 + 2 + H + (NBITS + 1) * C + 1;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    uart_rx_framer #(
        .TIMER_BITS      (32),
        .CLOCKS_PER_BAUD (C),
        .DATA_BITS       (NBITS)
    ) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed traffic: values sampled as the DUT will see them at the next posedge.
    int         valid_rises   = 0;
    int         ferr_cycles   = 0;
    int         ovr_cycles    = 0;
    int         last_rise_cyc = 0;
    logic       prev_valid    = 1'b0;
    logic [7:0] rx_bytes[$];

    always @(negedge clk) begin
        #2;
        if (!i_reset) begin
            if (o_valid && !prev_valid) begin
                valid_rises++;
                last_rise_cyc = cyc;
            end
            if (o_valid && i_ready) rx_bytes.push_back(o_data);
            ferr_cycles += int'(o_frame_err);
            ovr_cycles  += int'(o_overrun);
        end
        prev_valid = o_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bit(input logic v, input int spike_at);
        for (int i = 0; i < C; i++) begin
            i_rx = (i == spike_at) ? ~v : v;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_bit);
        drive_bit(1'b0, -1);
        for (int n = 0; n < NBITS; n++) drive_bit(b[n], (n == spike_bit) ? SPIKE_OFS : -1);
        drive_bit(stop, -1);
        i_rx = 1'b1;
    endtask

    task automatic idle_bits(input int nbits);
        i_rx = 1'b1;
        repeat (nbits * C) tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         spike_bit;
        logic [7:0] exp_data;
        int         exp_bytes;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k, nb, nf, no, nr, base, nbad;
        logic [7:0] exp_q[$];

        vecs[0] = '{8'h55, 1'b1, -1, 8'h55, 1, 0};
        vecs[1] = '{8'hA3, 1'b0, -1, 8'h00, 0, 1};
        vecs[2] = '{8'h3C, 1'b1, -1, 8'h3C, 1, 0};
        vecs[3] = '{8'h00, 1'b1,  3, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, -1, 8'hFF, 1, 0};
        vecs[5] = '{8'h5A, 1'b1,  0, 8'h5A, 1, 0};
        vecs[6] = '{8'h81, 1'b0, -1, 8'h00, 0, 1};

        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_ready = 1'b1;
        repeat (3) tick();
        check("reset_data",  32'(o_data), 32'h00);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_ferr",  32'(o_frame_err), 32'h0);
        check("reset_ovr",   32'(o_overrun), 32'h0);
        check("reset_busy",  32'(o_busy), 32'h0);
        i_reset = 1'b0;
        idle_bits(1);

        // Delivery latency from the start edge.
        k = cyc;
        nf = ferr_cycles;
        send_frame(8'h55, 1'b1, -1);
        idle_bits(1);
        check("latency", 32'(last_rise_cyc - k), 32'(LATENCY));
        check("lat_data", 32'(rx_bytes[$]), 32'h55);
        check("lat_noferr", 32'(ferr_cycles - nf), 32'd0);

        // Short low glitch: start rejected at the half-bit check.
        nr = valid_rises;
        nf = ferr_cycles;
        k = cyc;
        i_rx = 1'b0;
        repeat (3) tick();
        i_rx = 1'b1;
        while (cyc < k + 2 + H) tick();
        check("glitch_busy_before", 32'(o_busy), 32'h1);
        tick();
        check("glitch_busy_after", 32'(o_busy), 32'h0);
        idle_bits(2);
        check("glitch_no_valid", 32'(valid_rises - nr), 32'd0);
        check("glitch_no_ferr", 32'(ferr_cycles - nf), 32'd0);

        for (int v = 0; v < 7; v++) begin
            nb = rx_bytes.size();
            nf = ferr_cycles;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].spike_bit);
            idle_bits(2);
            check($sformatf("vec%0d_bytes", v), 32'(rx_bytes.size() - nb), 32'(vecs[v].exp_bytes));
            if (vecs[v].exp_bytes > 0)
                check($sformatf("vec%0d_data", v), 32'(rx_bytes[$]), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_ferr", v), 32'(ferr_cycles - nf), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_valid_idle", v), 32'(o_valid), 32'h0);
        end

        // Back-to-back frames while downstream stalls.
        i_ready = 1'b0;
        no = ovr_cycles;
        send_frame(8'h12, 1'b1, -1);
        send_frame(8'h34, 1'b1, -1);
        idle_bits(2);
        check("ovr_valid_held", 32'(o_valid), 32'h1);
        check("ovr_data_held", 32'(o_data), 32'h12);
        check("ovr_pulse", 32'(ovr_cycles - no), 32'd1);
        i_ready = 1'b1;
        tick();
        check("ovr_valid_clear", 32'(o_valid), 32'h0);
        check("ovr_accepted", 32'(rx_bytes[$]), 32'h12);

        // Reset during data bit 4, released while the line is still low.
        nr = valid_rises;
        nf = ferr_cycles;
        drive_bit(1'b0, -1);
        for (int n = 0; n < 4; n++) drive_bit(1'b1, -1);
        for (int i = 0; i < C; i++) begin
            i_rx = 1'b0;
            if (i == 4) i_reset = 1'b1;
            if (i == 7) i_reset = 1'b0;
            tick();
        end
        for (int n = 5; n < NBITS; n++) drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        idle_bits(2);
        check("rst_no_valid", 32'(valid_rises - nr), 32'd0);
        check("rst_no_ferr", 32'(ferr_cycles - nf), 32'd0);
        check("rst_idle", 32'(o_busy), 32'h0);
        send_frame(8'hFF, 1'b1, -1);
        idle_bits(2);
        check("rst_then_ff", 32'(rx_bytes[$]), 32'hFF);
        check("rst_then_ff_count", 32'(valid_rises - nr), 32'd1);

        // Randomized traffic against the frame-level model.
        base = rx_bytes.size();
        nf = ferr_cycles;
        no = ovr_cycles;
        nbad = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] b;
            logic       bad;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, !bad, -1);
            if (bad) begin
                nbad++;
                idle_bits(1 + int'($urandom_range(0, 1)));
            end else begin
                exp_q.push_back(b);
                idle_bits(int'($urandom_range(0, 1)));
            end
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        idle_bits(2);
        check("rand_count", 32'(rx_bytes.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_byte%0d", i), 32'(rx_bytes[base + i]), 32'(exp_q[i]));
        check("rand_ferr", 32'(ferr_cycles - nf), 32'(nbad));
        check("rand_no_ovr", 32'(ovr_cycles - no), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
